x_accel_reconstruction: RTL and testbench
=========================================

X_ACCEL_RECONSTRUCTION -- requirements
Module: x_accel_reconstruction

Interface
REQ-001 The block SHALL have parameter GRAVITY_OFFSET, default 16'sd1000, meaning the gravity bias added back to the reconstructed acceleration.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, the rising-edge clock for all state; rst input 1, synchronous active-high reset.
REQ-003 The block SHALL have port displacement, input, 32 signed, the X displacement sample.
REQ-004 The block SHALL have port dt, input, 16 unsigned, the time step for the sample.
REQ-005 The block SHALL have port data_valid, input, 1, which qualifies displacement and dt.
REQ-006 The block SHALL have port acc_x_raw, output reg, 16 signed, the reconstructed raw X acceleration.
REQ-007 The block SHALL have port output_valid, output reg, 1, a one-cycle pulse when acc_x_raw updates.
REQ-008 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 The block SHALL have port overrun, output reg, 1, a one-cycle pulse when data_valid arrives while busy.
REQ-010 The block SHALL have port dt_error, output reg, 1, a one-cycle pulse when a sample with dt==0 is rejected.

Function
REQ-011 The FSM SHALL have states IDLE, DIFF_V, DIV_V, DIFF_A, DIV_A and OUT.
REQ-012 In IDLE with data_valid=1 and dt!=0, the block SHALL latch displacement and dt, then go to DIFF_V.
REQ-013 In IDLE with data_valid=1 and dt==0, the block SHALL drop the sample, pulse dt_error for 1 cycle, leave all history unchanged and stay in IDLE.
REQ-014 When data_valid=1 in any non-IDLE state, the block SHALL ignore the sample and pulse overrun for 1 cycle, with no other effect.
REQ-015 In DIFF_V (1 cycle), the block SHALL form a 33-bit signed dd = disp - d_prev, then set d_prev <= disp.
REQ-016 In DIV_V (33 cycles), the block SHALL compute v = dd / dt with a sequential restoring divider, 1 quotient bit per cycle, on magnitudes.
- Sign is applied at the end.
- The quotient is truncated toward zero.
- The result is saturated to signed 32 bits.
REQ-017 In DIFF_A (1 cycle), the block SHALL form a 33-bit signed dv = v - v_prev, then set v_prev <= v.
REQ-018 In DIV_A (33 cycles), the block SHALL compute a = dv / dt using the same divider and the same truncation and saturation rules.
REQ-019 In OUT (1 cycle), the block SHALL:
- set acc_x_raw <= sat16(a + GRAVITY_OFFSET), where the sum is in 33 bits and clamps to [-32768, 32767];
- pulse output_valid;
- return to IDLE.
REQ-020 Latency SHALL be fixed at 69 cycles: output_valid rises on the 69th rising edge after the accepting edge.
- The block SHALL accept the next sample on the edge immediately after output_valid.
REQ-021 Priming: a 2-bit sample counter SHALL saturate at 2.
- 1st accepted sample: the block SHALL only load d_prev and return to IDLE after DIFF_V, without entering DIV_V.
- 2nd accepted sample: the block SHALL run DIFF_V and DIV_V, load v_prev <= v, and return to IDLE without entering DIFF_A.
- Neither priming sample SHALL assert output_valid.
REQ-022 acc_x_raw SHALL hold its last value between output_valid pulses.
REQ-023 A dividend of 0 SHALL yield a quotient of 0.
REQ-024 A dt of 1 SHALL yield quotient = dividend, subject to saturation.

Reset
REQ-025 When rst=1 on a clock edge, the block SHALL:
- force state to IDLE;
- clear acc_x_raw, output_valid, overrun, dt_error, d_prev, v_prev, the sample counter and the divider registers to 0.
REQ-026 Reset mid-operation SHALL abort the computation with no output_valid pulse, and the next sample SHALL restart priming.
REQ-027 data_valid SHALL be ignored in any cycle where rst=1.

Verification
REQ-028 dt=1, displacement 0, 10, 30 -> no output for samples 1-2; acc_x_raw=1010 with output_valid on edge 69 after sample 3 is accepted.
REQ-029 dt=2, displacement 0, 0, -3 -> v=-1 (truncation toward zero), a=0, acc_x_raw=1000.
REQ-030 dt=1, displacement 0, 0, 32'sh40000000 -> acc_x_raw=32767 (saturated); then displacement 0 -> acc_x_raw=-32768.
REQ-031 dt=0 on the 3rd sample -> dt_error pulses, no output, history unchanged; a following sample 30 with dt=1 after 0, 10 -> acc_x_raw=1010.
REQ-032 data_valid reasserted 5 cycles after acceptance -> overrun pulses once, and the in-flight result is unaffected.
REQ-033 rst pulsed during DIV_A -> outputs go to 0, and no output_valid appears until three new samples are accepted.

Source files
------------

// File: rtl/x_accel_reconstruction.sv
// Reconstructs raw X acceleration from displacement samples. It takes the second
// finite difference over dt using one shared sequential restoring divider, then
// adds back the gravity bias.
module x_accel_reconstruction #(
  parameter logic signed [15:0] GRAVITY_OFFSET = 16'sd1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] displacement,
  input  logic        [15:0] dt,
  input  logic               data_valid,
  output logic signed [15:0] acc_x_raw,
  output logic               output_valid,
  output logic               busy,
  output logic               overrun,
  output logic               dt_error
);

  typedef enum logic [2:0] {
    StIdle,
    StDiffV,
    StDivV,
    StDiffA,
    StDivA,
    StOut
  } state_e;

  localparam logic signed [33:0] MaxS32 = 34'sd2147483647;
  localparam logic signed [33:0] MinS32 = -34'sd2147483648;
  localparam logic signed [32:0] MaxS16 = 33'sd32767;
  localparam logic signed [32:0] MinS16 = -33'sd32768;

  state_e state_q, state_d;

  logic signed [31:0] disp_q;
  logic        [15:0] dt_q;
  logic signed [31:0] d_prev_q;
  logic signed [31:0] v_prev_q;
  logic        [1:0]  cnt_q;      // primed samples, saturates at 2
  logic        [15:0] rem_q;
  logic        [32:0] dvd_q;      // dividend shifts out, quotient shifts in
  logic               neg_q;
  logic        [5:0]  bit_cnt_q;
  logic signed [31:0] res_q;      // last signed, saturated quotient (v or a)

  logic signed [32:0] dd, dv, diff, sum33;
  logic        [32:0] load_mag;
  logic        [16:0] trial;
  logic               fits;
  logic        [15:0] rem_nxt;
  logic        [32:0] quot_nxt;
  logic signed [33:0] q_signed;
  logic signed [31:0] div_res;
  logic signed [15:0] acc_sat;
  logic               div_last;

  assign busy = (state_q != StIdle);

  // Datapath arithmetic: differences, one divider step, sign/saturation of results
  always_comb begin
    dd       = $signed({disp_q[31], disp_q}) - $signed({d_prev_q[31], d_prev_q});
    dv       = $signed({res_q[31], res_q}) - $signed({v_prev_q[31], v_prev_q});
    diff     = (state_q == StDiffV) ? dd : dv;
    load_mag = diff[32] ? $unsigned(-diff) : $unsigned(diff);

    trial    = {rem_q, dvd_q[32]};
    fits     = (trial >= {1'b0, dt_q});
    // remainder stays below dt, so the low 16 bits of the subtraction are exact
    rem_nxt  = fits ? (trial[15:0] - dt_q) : trial[15:0];
    quot_nxt = {dvd_q[31:0], fits};
    div_last = (bit_cnt_q == 6'd32);

    q_signed = neg_q ? -$signed({1'b0, quot_nxt}) : $signed({1'b0, quot_nxt});
    if (q_signed > MaxS32) begin
      div_res = 32'sh7fff_ffff;
    end else if (q_signed < MinS32) begin
      div_res = 32'sh8000_0000;
    end else begin
      div_res = q_signed[31:0];
    end

    sum33 = $signed({res_q[31], res_q}) + $signed({{17{GRAVITY_OFFSET[15]}}, GRAVITY_OFFSET});
    if (sum33 > MaxS16) begin
      acc_sat = 16'sh7fff;
    end else if (sum33 < MinS16) begin
      acc_sat = 16'sh8000;
    end else begin
      acc_sat = sum33[15:0];
    end
  end

  // Next-state logic; priming samples leave early without producing output
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (data_valid && (dt != 16'd0)) state_d = StDiffV;
      StDiffV: state_d = (cnt_q == 2'd0) ? StIdle : StDivV;
      StDivV:  if (div_last) state_d = (cnt_q == 2'd1) ? StIdle : StDiffA;
      StDiffA: state_d = StDivA;
      StDivA:  if (div_last) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers, history and pulsed status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q       <= '0;
      dt_q         <= '0;
      d_prev_q     <= '0;
      v_prev_q     <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      dvd_q        <= '0;
      neg_q        <= 1'b0;
      bit_cnt_q    <= '0;
      res_q        <= '0;
      acc_x_raw    <= '0;
      output_valid <= 1'b0;
      overrun      <= 1'b0;
      dt_error     <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      overrun      <= data_valid && (state_q != StIdle);
      dt_error     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (data_valid) begin
            if (dt == 16'd0) begin
              dt_error <= 1'b1;
            end else begin
              disp_q <= displacement;
              dt_q   <= dt;
            end
          end
        end
        StDiffV: begin
          d_prev_q <= disp_q;
          if (cnt_q == 2'd0) begin
            cnt_q <= 2'd1;
          end else begin
            dvd_q     <= load_mag;
            rem_q     <= '0;
            neg_q     <= dd[32];
            bit_cnt_q <= '0;
          end
        end
        StDivV, StDivA: begin
          rem_q     <= rem_nxt;
          dvd_q     <= quot_nxt;
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (div_last) begin
            res_q <= div_res;
            if ((state_q == StDivV) && (cnt_q == 2'd1)) begin
              v_prev_q <= div_res;
              cnt_q    <= 2'd2;
            end
          end
        end
        StDiffA: begin
          v_prev_q  <= res_q;
          dvd_q     <= load_mag;
          rem_q     <= '0;
          neg_q     <= dv[32];
          bit_cnt_q <= '0;
        end
        StOut: begin
          acc_x_raw    <= acc_sat;
          output_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x_accel_reconstruction.sv
// Self-checking bench: directed scenarios plus random samples against an
// arithmetic reference model of the second-difference reconstruction.
module tb_x_accel_reconstruction;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] displacement = '0;
  logic        [15:0] dt = '0;
  logic               data_valid = 1'b0;
  logic signed [15:0] acc_x_raw;
  logic               output_valid;
  logic               busy;
  logic               overrun;
  logic               dt_error;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  longint m_dprev, m_vprev;
  int     m_cnt;

  localparam longint Max32 = 64'sd2147483647;
  localparam longint Min32 = -64'sd2147483648;

  x_accel_reconstruction #(.GRAVITY_OFFSET(16'sd1000)) dut (
    .clk          (clk),
    .rst          (rst),
    .displacement (displacement),
    .dt           (dt),
    .data_valid   (data_valid),
    .acc_x_raw    (acc_x_raw),
    .output_valid (output_valid),
    .busy         (busy),
    .overrun      (overrun),
    .dt_error     (dt_error)
  );

  always #5 clk = ~clk;

  function automatic longint sat(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic void model_reset();
    m_dprev = 0;
    m_vprev = 0;
    m_cnt   = 0;
  endfunction

  // Velocity and acceleration by truncating division, saturated to 32 bits
  function automatic void model_step(input longint d, input longint t,
                                     output bit has_out, output longint val);
    longint v, a;
    has_out = 1'b0;
    val     = 0;
    if (t == 0) return;
    if (m_cnt == 0) begin
      m_dprev = d;
      m_cnt   = 1;
    end else begin
      v       = sat((d - m_dprev) / t, Min32, Max32);
      m_dprev = d;
      if (m_cnt == 1) begin
        m_vprev = v;
        m_cnt   = 2;
      end else begin
        a       = sat((v - m_vprev) / t, Min32, Max32);
        m_vprev = v;
        val     = sat(a + 1000, -32768, 32767);
        has_out = 1'b1;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Present one sample, then follow it to output or return to idle
  task automatic run_sample(input longint d, input longint t);
    bit                 exp_out;
    longint             exp_val;
    logic signed [15:0] ev16;
    int                 first;
    model_step(d, t, exp_out, exp_val);
    ev16 = 16'(exp_val);
    @(negedge clk);
    displacement = 32'(d);
    dt = 16'(t);
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    if (t == 0) begin
      vectors++;
      if (dt_error !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dt_error_pulse: got dt_error=%b busy=%b, want 1 0", dt_error, busy);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (dt_error !== 1'b0) begin
        errors++;
        $display("FAIL dt_error_width: got %b want 0", dt_error);
      end
      return;
    end
    first = -1;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk);
      #1;
      if (output_valid === 1'b1) begin
        first = e;
        break;
      end
      if (busy === 1'b0) break;
    end
    vectors++;
    if (exp_out) begin
      if (first !== 69) begin
        errors++;
        $display("FAIL latency: output_valid at edge %0d want 69", first);
      end
      vectors++;
      if (acc_x_raw !== ev16) begin
        errors++;
        $display("FAIL acc_x_raw: got %0d want %0d", acc_x_raw, ev16);
      end
    end else if (first != -1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL priming: output edge %0d busy=%b, want none and idle", first, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (acc_x_raw !== 16'sd0 || output_valid !== 1'b0 || busy !== 1'b0 ||
        overrun !== 1'b0 || dt_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: acc=%0d ov=%b busy=%b orun=%b dterr=%b, want all 0",
               acc_x_raw, output_valid, busy, overrun, dt_error);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_sample(0, 1);
    run_sample(10, 1);
    run_sample(30, 1);
    @(posedge clk);
    #1;
    vectors++;
    if (output_valid !== 1'b0 || acc_x_raw !== 16'sd1010) begin
      errors++;
      $display("FAIL hold: ov=%b acc=%0d want 0 1010", output_valid, acc_x_raw);
    end
  endtask

  task automatic test_truncation();
    do_reset();
    run_sample(0, 2);
    run_sample(0, 2);
    run_sample(-3, 2);
  endtask

  task automatic test_saturation();
    do_reset();
    run_sample(0, 1);
    run_sample(0, 1);
    run_sample(64'sh4000_0000, 1);
    run_sample(0, 1);
  endtask

  task automatic test_dt_zero();
    do_reset();
    run_sample(0, 1);
    run_sample(10, 1);
    run_sample(55, 0);
    run_sample(30, 1);
  endtask

  task automatic test_overrun();
    bit     eo;
    longint ev;
    int     ov_cnt, first;
    do_reset();
    run_sample(0, 1);
    run_sample(10, 1);
    model_step(30, 1, eo, ev);
    @(negedge clk);
    displacement = 32'sd30;
    dt = 16'd1;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    ov_cnt = 0;
    first = -1;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk);
      #1;
      if (overrun === 1'b1) ov_cnt++;
      if (output_valid === 1'b1) begin
        first = e;
        break;
      end
      if (e == 4) begin
        data_valid = 1'b1;
        displacement = -32'sd777;
        dt = 16'd3;
      end else begin
        data_valid = 1'b0;
      end
    end
    data_valid = 1'b0;
    vectors++;
    if (ov_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d want 1", ov_cnt);
    end
    vectors++;
    if (first !== 69 || acc_x_raw !== 16'(ev)) begin
      errors++;
      $display("FAIL overrun_result: edge %0d acc %0d want 69 %0d", first, acc_x_raw, ev);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_sample(0, 1);
    run_sample(10, 1);
    run_sample(30, 1);
    @(negedge clk);
    displacement = 32'sd30;
    dt = 16'd1;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    data_valid = 1'b1;
    displacement = 32'sd99;
    @(posedge clk);
    #1;
    vectors++;
    if (acc_x_raw !== 16'sd0 || output_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: acc=%0d ov=%b busy=%b orun=%b want 0 0 0 0",
               acc_x_raw, output_valid, busy, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || output_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b ov=%b want 0 0", busy, output_valid);
    end
    run_sample(0, 1);
    run_sample(10, 1);
    run_sample(30, 1);
  endtask

  task automatic test_random();
    longint d, t;
    int     r;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) d = longint'($signed(32'($urandom)));
      else d = longint'($urandom_range(0, 2000)) - 1000;
      r = $urandom_range(0, 9);
      if (r == 0) t = 0;
      else if (r == 1) t = $urandom_range(1, 65535);
      else t = $urandom_range(1, 4);
      run_sample(d, t);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_sample(0, 1);
    run_sample(5, 1);
    for (int i = 0; i < 4; i++) run_sample(longint'(i * i * 7) - 20, 1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_truncation();
    test_saturation();
    test_dt_zero();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
